// File: rtl/axi4_lite_slave_read.sv
// AXI4-Lite read responder: one AR at a time, fixed-latency synchronous memory port.
// Define AXI4_LITE_SLAVE_READ_ALIGN_CHECK_EN to answer misaligned in-range reads with SLVERR.
module axi4_lite_slave_read #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter logic [63:0] MEM_BASE       = 64'h0,
  parameter int unsigned MEM_SIZE       = 4096,
  parameter int unsigned MEM_LATENCY    = 1,
  localparam int unsigned BYTE_OFF      = $clog2(AXI_DATA_WIDTH / 8),
  localparam int unsigned MEM_AW        = $clog2(MEM_SIZE) - BYTE_OFF
) (
  input  logic                      clk_i,
  input  logic                      arst_i,
  input  logic                      AR_VALID,
  output logic                      AR_READY,
  input  logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
  input  logic [2:0]                AR_PROT,
  output logic                      R_VALID,
  input  logic                      R_READY,
  output logic [AXI_DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]                R_RESP,
  output logic                      mem_rd_en_o,
  output logic [MEM_AW-1:0]         mem_addr_o,
  input  logic [AXI_DATA_WIDTH-1:0] mem_data_i
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BaseA = AXI_ADDR_WIDTH'(MEM_BASE);
  localparam logic [AXI_ADDR_WIDTH-1:0] SizeA = AXI_ADDR_WIDTH'(MEM_SIZE);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {StIdle, StMemReq, StMemWait, StResp} state_e;

  state_e                    state_q, state_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic [AXI_DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]                r_resp_q, r_resp_d;
  logic [MEM_AW-1:0]         mem_addr_q, mem_addr_d;

  logic [AXI_ADDR_WIDTH-1:0] offset;
  logic                      dec_err;
  logic                      misalign;
  logic                      unused_bits;

  // Offset is only meaningful once AR_ADDR >= base, so no wrap reaches the range check.
  assign offset  = AR_ADDR - BaseA;
  assign dec_err = (AR_ADDR < BaseA) || (offset >= SizeA);

`ifdef AXI4_LITE_SLAVE_READ_ALIGN_CHECK_EN
  assign misalign = |AR_ADDR[BYTE_OFF-1:0];
`else
  assign misalign = 1'b0;
`endif

  assign unused_bits = ^{offset, AR_PROT};

  // State register
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (AR_VALID) begin
          state_d = (dec_err || misalign) ? StResp : StMemReq;
        end
      end
      StMemReq:  state_d = StMemWait;
      StMemWait: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (R_READY) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  // Output decode, registered state only
  always_comb begin
    AR_READY    = 1'b0;
    R_VALID     = 1'b0;
    mem_rd_en_o = 1'b0;
    unique case (state_q)
      StIdle:    AR_READY    = 1'b1;
      StMemReq:  mem_rd_en_o = 1'b1;
      StMemWait: ;
      StResp:    R_VALID     = 1'b1;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d      = cnt_q;
    r_data_d   = r_data_q;
    r_resp_d   = r_resp_q;
    mem_addr_d = mem_addr_q;
    unique case (state_q)
      StIdle: begin
        if (AR_VALID) begin
          if (dec_err) begin
            r_resp_d = RespDecErr;
            r_data_d = '0;
          end else if (misalign) begin
            r_resp_d = RespSlvErr;
            r_data_d = '0;
          end else begin
            r_resp_d   = RespOkay;
            mem_addr_d = offset[BYTE_OFF +: MEM_AW];
          end
        end
      end
      StMemReq:  cnt_d = CntW'(MEM_LATENCY);
      StMemWait: begin
        if (cnt_q == CntW'(1)) begin
          r_data_d = mem_data_i;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q      <= '0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
      mem_addr_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign R_DATA     = r_data_q;
  assign R_RESP     = r_resp_q;
  assign mem_addr_o = mem_addr_q;

endmodule

// File: tb/tb_axi4_lite_slave_read.sv
// Bench for axi4_lite_slave_read: three instances (latency 2, 1, 4) with a delay-line memory
// model and a scoreboard of expected R beats.
module tb_axi4_lite_slave_read;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam int unsigned NDUT = 3;

  typedef struct packed {
    logic [1:0]  dev;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  logic        clk;
  logic        arst;
  logic        ar_valid  [NDUT];
  logic        ar_ready  [NDUT];
  logic [63:0] ar_addr   [NDUT];
  logic [2:0]  ar_prot   [NDUT];
  logic        r_valid   [NDUT];
  logic        r_ready   [NDUT];
  logic [31:0] r_data    [NDUT];
  logic [1:0]  r_resp    [NDUT];
  logic        mem_rd_en [NDUT];
  logic [9:0]  mem_addr  [NDUT];
  logic [31:0] mem_data  [NDUT];

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   cycle;
  int   hs_cnt  [NDUT];
  int   hs_last [NDUT];
  int   hs_gap  [NDUT];

  always #5 clk = ~clk;

  function automatic logic [31:0] memw(input logic [9:0] idx);
    return (idx == 10'd4) ? 32'hDEAD_BEEF : 32'hA500_0000 + 32'(idx) * 32'h0001_0101;
  endfunction

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : ((d == 1) ? 1 : 4);
  endfunction

  function automatic string tg(input string s, input int d);
    return $sformatf("%s_d%0d", s, d);
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic [31:0] pipe [L];
    logic        vld  [L];

    // Data is valid only L cycles after the strobe; junk otherwise.
    always_ff @(posedge clk) begin
      if (arst) begin
        for (int i = 0; i < int'(L); i++) vld[i] <= 1'b0;
      end else begin
        vld[0] <= mem_rd_en[g];
        for (int i = 1; i < int'(L); i++) vld[i] <= vld[i-1];
      end
      pipe[0] <= memw(mem_addr[g]);
      for (int i = 1; i < int'(L); i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data[g] = vld[L-1] ? pipe[L-1] : 32'hBADC_0FFE;

    axi4_lite_slave_read #(
      .AXI_ADDR_WIDTH(64),
      .AXI_DATA_WIDTH(32),
      .MEM_BASE      (BASE),
      .MEM_SIZE      (4096),
      .MEM_LATENCY   (L)
    ) u_dut (
      .clk_i      (clk),
      .arst_i     (arst),
      .AR_VALID   (ar_valid[g]),
      .AR_READY   (ar_ready[g]),
      .AR_ADDR    (ar_addr[g]),
      .AR_PROT    (ar_prot[g]),
      .R_VALID    (r_valid[g]),
      .R_READY    (r_ready[g]),
      .R_DATA     (r_data[g]),
      .R_RESP     (r_resp[g]),
      .mem_rd_en_o(mem_rd_en[g]),
      .mem_addr_o (mem_addr[g]),
      .mem_data_i (mem_data[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inspect handshakes about to happen at the next posedge, then advance one cycle.
  task automatic cyc();
    exp_t e;
    for (int d = 0; d < int'(NDUT); d++) begin
      if (r_valid[d] && r_ready[d]) begin
        chk(tg("beat_expected", d), 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk(tg("beat_dev", d), 64'(e.dev), 64'(d));
          chk(tg("r_data", d), 64'(r_data[d]), 64'(e.data));
          chk(tg("r_resp", d), 64'(r_resp[d]), 64'(e.resp));
        end
      end
      if (ar_valid[d] && ar_ready[d]) begin
        hs_gap[d]  = cycle - hs_last[d];
        hs_last[d] = cycle;
        hs_cnt[d]++;
      end
    end
    @(negedge clk);
    cycle++;
  endtask

  task automatic check_reset_vals(input int d);
    chk(tg("rst_ar_ready", d), 64'(ar_ready[d]), 64'd1);
    chk(tg("rst_r_valid", d), 64'(r_valid[d]), 64'd0);
    chk(tg("rst_r_data", d), 64'(r_data[d]), 64'd0);
    chk(tg("rst_r_resp", d), 64'(r_resp[d]), 64'd0);
    chk(tg("rst_mem_rd_en", d), 64'(mem_rd_en[d]), 64'd0);
    chk(tg("rst_mem_addr", d), 64'(mem_addr[d]), 64'd0);
  endtask

  function automatic exp_t mk_exp(input int d, input logic [63:0] addr, input logic [1:0] resp);
    exp_t        e;
    logic [63:0] off;
    off    = addr - BASE;
    e.dev  = 2'(d);
    e.resp = resp;
    e.data = (resp == 2'b00) ? memw(off[11:2]) : 32'h0;
    return e;
  endfunction

  // Single read with R_READY high; checks cycle-exact timing of strobe and R_VALID.
  task automatic do_read(input int d, input logic [63:0] addr, input logic [1:0] resp);
    logic [63:0] off;
    int          lat_exp;
    off     = addr - BASE;
    lat_exp = (resp == 2'b00) ? 2 + lat_of(d) : 1;
    chk(tg("ar_ready_idle", d), 64'(ar_ready[d]), 64'd1);
    ar_valid[d] = 1'b1;
    ar_addr[d]  = addr;
    r_ready[d]  = 1'b1;
    sb.push_back(mk_exp(d, addr, resp));
    cyc();
    ar_valid[d] = 1'b0;
    for (int t = 1; t < lat_exp; t++) begin
      chk(tg("r_valid_early", d), 64'(r_valid[d]), 64'd0);
      chk(tg("ar_ready_busy", d), 64'(ar_ready[d]), 64'd0);
      chk(tg("mem_rd_en", d), 64'(mem_rd_en[d]), 64'(t == 1));
      if (t == 1) chk(tg("mem_addr", d), 64'(mem_addr[d]), 64'(off[11:2]));
      cyc();
    end
    chk(tg("r_valid_on_time", d), 64'(r_valid[d]), 64'd1);
    chk(tg("mem_rd_en_resp", d), 64'(mem_rd_en[d]), 64'd0);
    chk(tg("ar_ready_resp", d), 64'(ar_ready[d]), 64'd0);
    cyc();
    chk(tg("ar_ready_after", d), 64'(ar_ready[d]), 64'd1);
    chk(tg("r_valid_after", d), 64'(r_valid[d]), 64'd0);
  endtask

  // AR_VALID held high across two reads: handshakes must be exactly latency+3 apart.
  task automatic b2b(input int d);
    logic [63:0] addr;
    int          n0;
    addr = 64'h8000_0040;
    sb.push_back(mk_exp(d, addr, 2'b00));
    sb.push_back(mk_exp(d, addr, 2'b00));
    n0          = hs_cnt[d];
    ar_valid[d] = 1'b1;
    ar_addr[d]  = addr;
    r_ready[d]  = 1'b1;
    for (int t = 0; t < 60 && hs_cnt[d] < n0 + 2; t++) cyc();
    ar_valid[d] = 1'b0;
    chk(tg("b2b_handshakes", d), 64'(hs_cnt[d] - n0), 64'd2);
    chk(tg("b2b_period", d), 64'(hs_gap[d]), 64'(lat_of(d) + 3));
    for (int t = 0; t < 60 && sb.size() != 0; t++) cyc();
    chk(tg("b2b_drained", d), 64'(sb.size()), 64'd0);
  endtask

  initial begin
    exp_t e;
    clk      = 1'b0;
    arst     = 1'b1;
    n_checks = 0;
    n_errors = 0;
    cycle    = 0;
    for (int d = 0; d < int'(NDUT); d++) begin
      ar_valid[d] = 1'b0;
      ar_addr[d]  = 64'h0;
      ar_prot[d]  = 3'b010;
      r_ready[d]  = 1'b0;
      hs_cnt[d]   = 0;
      hs_last[d]  = 0;
      hs_gap[d]   = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < int'(NDUT); d++) check_reset_vals(d);
    arst = 1'b0;
    cyc();
    cyc();

    // Legal reads, including the last word in range
    do_read(0, 64'h8000_0010, 2'b00);
    do_read(0, 64'h8000_0FFC, 2'b00);
    // Out of range above and below
    do_read(0, 64'h8000_1000, 2'b11);
    do_read(0, 64'h7FFF_FFFC, 2'b11);
    do_read(0, 64'hFFFF_FFFF_8000_0010, 2'b11);
    // Misaligned
`ifdef AXI4_LITE_SLAVE_READ_ALIGN_CHECK_EN
    do_read(0, 64'h8000_0002, 2'b10);
`else
    do_read(0, 64'h8000_0002, 2'b00);
`endif

    // Backpressure: 10 cycles with R_READY low, AR_VALID pushing a different address
    e = mk_exp(0, 64'h8000_0008, 2'b00);
    sb.push_back(e);
    ar_valid[0] = 1'b1;
    ar_addr[0]  = 64'h8000_0008;
    r_ready[0]  = 1'b0;
    cyc();
    ar_valid[0] = 1'b0;
    repeat (3) cyc();
    chk("bp_r_valid_rise", 64'(r_valid[0]), 64'd1);
    for (int i = 0; i < 10; i++) begin
      ar_valid[0] = 1'b1;
      ar_addr[0]  = 64'h8000_0030;
      chk("bp_r_valid", 64'(r_valid[0]), 64'd1);
      chk("bp_r_data", 64'(r_data[0]), 64'(e.data));
      chk("bp_r_resp", 64'(r_resp[0]), 64'(e.resp));
      chk("bp_ar_ready", 64'(ar_ready[0]), 64'd0);
      cyc();
    end
    ar_valid[0] = 1'b0;
    r_ready[0]  = 1'b1;
    cyc();
    chk("bp_ar_ready_after", 64'(ar_ready[0]), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_no_extra_beat", 64'(r_valid[0]), 64'd0);
      cyc();
    end

    // Reset during MEM_WAIT
    sb.push_back(mk_exp(0, 64'h8000_0020, 2'b00));
    ar_valid[0] = 1'b1;
    ar_addr[0]  = 64'h8000_0020;
    cyc();
    ar_valid[0] = 1'b0;
    cyc();
    chk("rst_pre_mem_addr", 64'(mem_addr[0]), 64'd8);
    arst = 1'b1;
    #1;
    check_reset_vals(0);
    void'(sb.pop_back());
    cyc();
    arst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("rst_no_beat", 64'(r_valid[0]), 64'd0);
      cyc();
    end
    do_read(0, 64'h8000_0024, 2'b00);

    // Latency sweep and back-to-back period
    do_read(1, 64'h8000_0010, 2'b00);
    do_read(2, 64'h8000_0014, 2'b00);
    do_read(1, 64'h8000_1000, 2'b11);
    b2b(0);
    b2b(1);
    b2b(2);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axi4_lite_slave_read.md
# axi4_lite_slave_read

AXI4-Lite read-channel responder (slave) bridging AR/R handshakes to a synchronous on-chip memory port. Sits on the memory side of the interconnect, opposite the core's AXI4-Lite read master. Serves one transaction at a time with fixed memory latency. Returns DECERR/SLVERR responses for illegal addresses without touching memory.

## Interface
- AXI_ADDR_WIDTH, 64, AR_ADDR width.
- AXI_DATA_WIDTH, 32, R_DATA / mem_data_i width; must be 32 or 64.
- MEM_BASE, 64'h0, byte address of first memory word.
- MEM_SIZE, 4096, memory size in bytes; power of two, multiple of AXI_DATA_WIDTH/8.
- MEM_LATENCY, 1, cycles from mem_rd_en_o to valid mem_data_i; must be >= 1.
- Derived: BYTE_OFF = $clog2(AXI_DATA_WIDTH/8); MEM_AW = $clog2(MEM_SIZE) - BYTE_OFF.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset: asynchronous, active-high. Clock is clk_i.
- AR_VALID  in  1  read address valid.
- AR_READY  out  1  read address ready.
- AR_ADDR  in  AXI_ADDR_WIDTH  byte address.
- AR_PROT  in  3  accepted, ignored.
- R_VALID  out  1  read data valid.
- R_READY  in  1  master ready for data.
- R_DATA  out  AXI_DATA_WIDTH  read data.
- R_RESP  out  2  2'b00 OKAY, 2'b10 SLVERR, 2'b11 DECERR.
- mem_rd_en_o  out  1  one-cycle memory read strobe.
- mem_addr_o  out  MEM_AW  word index (AR_ADDR - MEM_BASE) >> BYTE_OFF.
- mem_data_i  in  AXI_DATA_WIDTH  memory read data.

## Operation
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP. Reset state IDLE.
- IDLE: AR_READY = 1. On AR_VALID & AR_READY, latch address and classify:
  - DECERR if AR_ADDR < MEM_BASE or (AR_ADDR - MEM_BASE) >= MEM_SIZE. Compare at full AXI_ADDR_WIDTH, with no wrap-around.
  - else SLVERR if the alignment check is enabled (see Configuration) and AR_ADDR[BYTE_OFF-1:0] != 0. DECERR takes priority.
  - error: next state RESP, R_DATA = 0, R_RESP = error code. Memory is not accessed.
  - legal: next state MEM_REQ, R_RESP = OKAY.
- MEM_REQ: mem_rd_en_o = 1 for exactly this cycle, with mem_addr_o valid. Load latency counter with MEM_LATENCY. Next state MEM_WAIT.
- MEM_WAIT: counter decrements each cycle. When it reaches 1, capture mem_data_i into R_DATA at that clock edge and go to RESP.
- RESP: R_VALID = 1. R_DATA and R_RESP stay stable until R_READY. On R_VALID & R_READY, go to IDLE.
- AR_READY = 0 in every state except IDLE. No address is accepted while a response is pending.
- AR_READY, R_VALID and mem_rd_en_o decode from the registered state only. There is no combinational path from inputs to them.
- mem_addr_o holds its value outside MEM_REQ. mem_data_i is ignored except at the capture edge.

## Timing
- Reset values: AR_READY 1 (IDLE), R_VALID 0, R_DATA 0, R_RESP 2'b00, mem_rd_en_o 0, mem_addr_o 0.
- Legal read: handshake in cycle 0, mem_rd_en_o in cycle 1, data captured at end of cycle 1+MEM_LATENCY, R_VALID from cycle 2+MEM_LATENCY.
- Error read: handshake in cycle 0, R_VALID in cycle 1.
- After the R handshake in cycle n, AR_READY = 1 in cycle n+1.
- Minimum legal-read period is MEM_LATENCY+3 cycles with R_READY held high.
- R_READY low in RESP: hold indefinitely, with no change to any output.
- R_READY high before R_VALID: has no effect.
- arst_i mid-transaction: immediately returns to IDLE with reset output values. In-flight memory data is discarded, and no R beat is produced for the aborted address.

## Configuration
- Macro: AXI4_LITE_SLAVE_READ_ALIGN_CHECK_EN.
- Defined: in-range addresses with nonzero low BYTE_OFF bits respond SLVERR, with R_DATA 0 and no memory access.
- Undefined: low BYTE_OFF bits are silently dropped, the word read proceeds, and the response is OKAY. The FSM never produces SLVERR.

## Test plan
All scenarios use MEM_BASE=0x8000_0000, MEM_SIZE=4096, 32-bit data, and MEM_LATENCY=2 unless stated.
- Legal read: AR 0x8000_0010, memory returns 0xDEADBEEF, R_READY=1. Required: mem_rd_en_o in cycle 1 with mem_addr_o=4; R_VALID in cycle 4 with R_DATA=0xDEADBEEF and R_RESP=00; AR_READY=1 in cycle 5.
- Out-of-range: AR 0x8000_1000, then 0x7FFF_FFFC. Required for each: R_VALID in cycle 1, R_RESP=11, R_DATA=0, and mem_rd_en_o never asserted.
- Misaligned: AR 0x8000_0002. Required with the macro defined: SLVERR in cycle 1. Required with the macro undefined: OKAY with word 0 data.
- Backpressure: hold R_READY=0 for 10 cycles in RESP. Required: R_VALID, R_DATA and R_RESP stable, AR_READY=0 throughout, and AR_VALID ignored.
- Reset mid-read: assert arst_i during MEM_WAIT. Required: outputs at reset values immediately, no R beat afterwards, and the next AR is served normally.
- Latency sweep: MEM_LATENCY in {1,4}. Required: R_VALID at cycle 2+MEM_LATENCY, and back-to-back reads spaced exactly MEM_LATENCY+3 cycles apart.
